// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame scheduler for the framebuffer write path.
// Each frame runs three phases in order: erase old objects (clear engine),
// advance game state (physics), draw new objects (draw engine). The block
// owns the single framebuffer write port and muxes the clear/draw engines onto it.
// Optional feature macro: PAUSE_EN (pause input holds the sequencer in IDLE).
//
// state  | meaning
// IDLE   | waiting for frame_tick or a pending tick
// CLEAR  | clear engine erasing old objects, writes background colour
// UPDATE | physics engine advancing game state, no writes
// DRAW   | draw engine drawing new objects, writes foreground colour
module frame_sequencer #(
   parameter int COORD_W          = 11,
   parameter int H_RES            = 640,
   parameter int V_RES            = 480,
   parameter int MAX_PHASE_CYCLES = 524288
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               pause,
   output logic               clear_start,
   input  logic               clear_done,
   input  logic [COORD_W-1:0] clear_x,
   input  logic [COORD_W-1:0] clear_y,
   output logic               physics_start,
   input  logic               physics_done,
   output logic               draw_start,
   input  logic               draw_done,
   input  logic [COORD_W-1:0] draw_x,
   input  logic [COORD_W-1:0] draw_y,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic               pix_color,
   output logic               pix_we,
   output logic               busy,
   output logic [7:0]         overrun,
   output logic               wdog_err
);

   typedef enum logic [1:0] {IDLE, CLEAR, UPDATE, DRAW} state_t;

   localparam int WD_W = (MAX_PHASE_CYCLES > 2) ? $clog2(MAX_PHASE_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_PHASE_CYCLES - 1);

   state_t               state_q, state_d;
   logic                 pending_q, pending_d;
   logic [7:0]           overrun_q, overrun_d;
   logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
   logic                 wdog_err_q, wdog_err_d;
   logic                 clear_start_q, clear_start_d;
   logic                 physics_start_q, physics_start_d;
   logic                 draw_start_q, draw_start_d;
   logic [COORD_W-1:0]   pix_x_q, pix_x_d;
   logic [COORD_W-1:0]   pix_y_q, pix_y_d;
   logic                 pix_color_q, pix_color_d;
   logic                 pix_we_q, pix_we_d;

   logic hold;
   logic go;
   logic wd_hit;
   logic clr_vis;
   logic drw_vis;

`ifdef PAUSE_EN
   assign hold = pause;
`else
   // pause port kept for pin compatibility but has no effect in this build
   logic unused_pause;
   assign unused_pause = pause;
   assign hold = 1'b0;
`endif

   assign go      = (state_q == IDLE) && (frame_tick || pending_q) && !hold;
   assign wd_hit  = (state_q != IDLE) && (wd_cnt_q == WD_LAST);
   assign clr_vis = (clear_x < COORD_W'(H_RES)) && (clear_y < COORD_W'(V_RES));
   assign drw_vis = (draw_x < COORD_W'(H_RES)) && (draw_y < COORD_W'(V_RES));

   // Next-state, tick bookkeeping, watchdog and write-port mux
   always_comb begin
      state_d         = state_q;
      pending_d       = pending_q;
      overrun_d       = overrun_q;
      wdog_err_d      = wdog_err_q;
      clear_start_d   = 1'b0;
      physics_start_d = 1'b0;
      draw_start_d    = 1'b0;
      pix_x_d         = pix_x_q;
      pix_y_d         = pix_y_q;
      pix_color_d     = pix_color_q;
      pix_we_d        = 1'b0;

      // A tick arriving together with a consumed pending tick becomes the new pending one
      if (go) begin
         pending_d = frame_tick && pending_q;
      end else if (frame_tick) begin
         if (!pending_q)
            pending_d = 1'b1;
         else if (overrun_q != 8'hFF)
            overrun_d = overrun_q + 8'd1;
      end

      case (state_q)
         IDLE: begin
            if (go) begin
               state_d       = CLEAR;
               clear_start_d = 1'b1;
            end
         end
         CLEAR: begin
            pix_x_d     = clear_x;
            pix_y_d     = clear_y;
            pix_color_d = 1'b0;
            pix_we_d    = !clear_start_q && clr_vis;
            if (clear_done) begin
               state_d         = UPDATE;
               physics_start_d = 1'b1;
            end
         end
         UPDATE: begin
            if (physics_done) begin
               state_d      = DRAW;
               draw_start_d = 1'b1;
            end
         end
         DRAW: begin
            pix_x_d     = draw_x;
            pix_y_d     = draw_y;
            pix_color_d = 1'b1;
            pix_we_d    = !draw_start_q && drw_vis;
            if (draw_done)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Watchdog overrides any phase completion in the same cycle
      if (wd_hit) begin
         state_d         = IDLE;
         wdog_err_d      = 1'b1;
         pix_we_d        = 1'b0;
         physics_start_d = 1'b0;
         draw_start_d    = 1'b0;
      end

      if ((state_d != state_q) || (state_q == IDLE))
         wd_cnt_d = '0;
      else
         wd_cnt_d = wd_cnt_q + WD_W'(1);
   end

   // State and output registers, synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         pending_q       <= 1'b0;
         overrun_q       <= 8'd0;
         wd_cnt_q        <= '0;
         wdog_err_q      <= 1'b0;
         clear_start_q   <= 1'b0;
         physics_start_q <= 1'b0;
         draw_start_q    <= 1'b0;
         pix_x_q         <= '0;
         pix_y_q         <= '0;
         pix_color_q     <= 1'b0;
         pix_we_q        <= 1'b0;
      end else begin
         state_q         <= state_d;
         pending_q       <= pending_d;
         overrun_q       <= overrun_d;
         wd_cnt_q        <= wd_cnt_d;
         wdog_err_q      <= wdog_err_d;
         clear_start_q   <= clear_start_d;
         physics_start_q <= physics_start_d;
         draw_start_q    <= draw_start_d;
         pix_x_q         <= pix_x_d;
         pix_y_q         <= pix_y_d;
         pix_color_q     <= pix_color_d;
         pix_we_q        <= pix_we_d;
      end
   end

   assign clear_start   = clear_start_q;
   assign physics_start = physics_start_q;
   assign draw_start    = draw_start_q;
   assign pix_x         = pix_x_q;
   assign pix_y         = pix_y_q;
   assign pix_color     = pix_color_q;
   assign pix_we        = pix_we_q;
   assign busy          = (state_q != IDLE);
   assign overrun       = overrun_q;
   assign wdog_err      = wdog_err_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Testbench for frame_sequencer: engine responder model plus event and
// pixel-write scoreboards. Honours PAUSE_EN the same way the design does.
module tb_frame_sequencer;

   localparam int CW = 11;

   logic          clk = 1'b0;
   logic          reset, frame_tick, pause;
   logic          clear_done, physics_done, draw_done;
   logic [CW-1:0] clear_x, clear_y, draw_x, draw_y;
   logic          clear_start, physics_start, draw_start;
   logic [CW-1:0] pix_x, pix_y;
   logic          pix_color, pix_we, busy, wdog_err;
   logic [7:0]    overrun;

   always #5 clk = ~clk;

   frame_sequencer #(
      .COORD_W(CW), .H_RES(640), .V_RES(480), .MAX_PHASE_CYCLES(64)
   ) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .pause(pause),
      .clear_start(clear_start), .clear_done(clear_done),
      .clear_x(clear_x), .clear_y(clear_y),
      .physics_start(physics_start), .physics_done(physics_done),
      .draw_start(draw_start), .draw_done(draw_done),
      .draw_x(draw_x), .draw_y(draw_y),
      .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_we(pix_we),
      .busy(busy), .overrun(overrun), .wdog_err(wdog_err)
   );

   typedef struct { int kind; int cyc; } ev_t;
   typedef struct { int cyc; logic [CW-1:0] x; logic [CW-1:0] y; logic c; logic we; } px_t;

   ev_t exp_q[$];
   ev_t obs_q[$];
   px_t px_q[$];

   int cyc;
   int n_pass, n_total;
   int clr_dly, phy_dly, drw_dly;
   int clr_tmr, phy_tmr, drw_tmr;

   // One clock: sample after the edge, log start pulses, model engine done responses
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      clear_done   = 1'b0;
      physics_done = 1'b0;
      draw_done    = 1'b0;
      if (reset) begin
         clr_tmr = 0; phy_tmr = 0; drw_tmr = 0;
      end else begin
         if (clr_tmr > 0) begin clr_tmr--; if (clr_tmr == 0) clear_done = 1'b1; end
         if (phy_tmr > 0) begin phy_tmr--; if (phy_tmr == 0) physics_done = 1'b1; end
         if (drw_tmr > 0) begin drw_tmr--; if (drw_tmr == 0) draw_done = 1'b1; end
         if (clear_start) begin
            obs_q.push_back('{1, cyc});
            if (clr_dly > 0) clr_tmr = clr_dly;
         end
         if (physics_start) begin
            obs_q.push_back('{2, cyc});
            if (phy_dly > 0) phy_tmr = phy_dly;
         end
         if (draw_start) begin
            obs_q.push_back('{3, cyc});
            if (drw_dly > 0) drw_tmr = drw_dly;
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; frame_tick = 1'b0; pause = 1'b0;
      step();
      step();
      reset = 1'b0;
      obs_q.delete();
      exp_q.delete();
      px_q.delete();
   endtask

   task automatic test_reset();
      logic [7:0] obs;
      do_reset();
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
      obs = {5'd0, clear_start, physics_start, draw_start};
      n_total++; if (obs !== 8'd0) $display("FAIL reset_starts got=%b exp=000", obs[2:0]); else n_pass++;
      n_total++; if (pix_x !== '0 || pix_y !== '0) $display("FAIL reset_pix_xy got=%0d,%0d exp=0,0", pix_x, pix_y); else n_pass++;
      n_total++; if (pix_color !== 1'b0) $display("FAIL reset_color got=%b exp=0", pix_color); else n_pass++;
      n_total++; if (pix_we !== 1'b0) $display("FAIL reset_we got=%b exp=0", pix_we); else n_pass++;
      n_total++; if (overrun !== 8'd0) $display("FAIL reset_overrun got=%0d exp=0", overrun); else n_pass++;
      n_total++; if (wdog_err !== 1'b0) $display("FAIL reset_wdog got=%b exp=0", wdog_err); else n_pass++;
   endtask

   task automatic test_frame();
      int t0, busy_n, guard;
      do_reset();
      t0 = cyc;
      frame_tick = 1'b1;
      exp_q.push_back('{1, t0 + 1});
      exp_q.push_back('{2, t0 + 12});
      exp_q.push_back('{3, t0 + 23});
      step();
      frame_tick = 1'b0;
      busy_n = 0; guard = 0;
      while (busy === 1'b1 && guard < 100) begin
         busy_n++;
         if (cyc == t0 + 3) begin
            physics_done = 1'b1;
            draw_done    = 1'b1;
         end
         step();
         guard++;
      end
      n_total++; if (busy_n !== 33) $display("FAIL frame_busy_cycles got=%0d exp=33", busy_n); else n_pass++;
      n_total++; if (obs_q.size() !== exp_q.size()) $display("FAIL frame_event_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         ev_t e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_total++;
         if (o.kind !== e.kind || o.cyc !== e.cyc)
            $display("FAIL frame_event got=kind%0d@%0d exp=kind%0d@%0d", o.kind, o.cyc - t0, e.kind, e.cyc - t0);
         else n_pass++;
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_pixels();
      int s, rel;
      do_reset();
      clear_x = 0; clear_y = 0; draw_x = 0; draw_y = 0;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      s = cyc;
      for (rel = 0; rel <= 35; rel++) begin
         if (px_q.size() > 0 && px_q[0].cyc == cyc) begin
            px_t e;
            e = px_q.pop_front();
            n_total++;
            if ({pix_x, pix_y, pix_color, pix_we} !== {e.x, e.y, e.c, e.we})
               $display("FAIL pixel@rel%0d got=x%0d y%0d c%b we%b exp=x%0d y%0d c%b we%b",
                        rel, pix_x, pix_y, pix_color, pix_we, e.x, e.y, e.c, e.we);
            else n_pass++;
         end
         case (rel)
            0:  begin clear_x = 50;  clear_y = 60;  px_q.push_back('{cyc + 1, 50, 60, 1'b0, 1'b0}); end
            1:  begin clear_x = 100; clear_y = 200; px_q.push_back('{cyc + 1, 100, 200, 1'b0, 1'b1}); end
            3:  begin clear_x = 700; clear_y = 5;   px_q.push_back('{cyc + 1, 700, 5, 1'b0, 1'b0}); end
            4:  begin clear_x = 100; clear_y = 481; px_q.push_back('{cyc + 1, 100, 481, 1'b0, 1'b0}); end
            5:  begin clear_x = 100; clear_y = 200; px_q.push_back('{cyc + 1, 100, 200, 1'b0, 1'b1}); end
            12: px_q.push_back('{cyc + 1, 100, 200, 1'b0, 1'b0});
            22: begin draw_x = 3;   draw_y = 3;   px_q.push_back('{cyc + 1, 3, 3, 1'b1, 1'b0}); end
            23: begin draw_x = 5;   draw_y = 7;   px_q.push_back('{cyc + 1, 5, 7, 1'b1, 1'b1}); end
            24: begin draw_x = 639; draw_y = 479; px_q.push_back('{cyc + 1, 639, 479, 1'b1, 1'b1}); end
            25: begin draw_x = 640; draw_y = 0;   px_q.push_back('{cyc + 1, 640, 0, 1'b1, 1'b0}); end
            26: begin draw_x = 0;   draw_y = 480; px_q.push_back('{cyc + 1, 0, 480, 1'b1, 1'b0}); end
            27: begin draw_x = 10;  draw_y = 10;  px_q.push_back('{cyc + 1, 10, 10, 1'b1, 1'b1}); end
            33: px_q.push_back('{cyc + 1, 10, 10, 1'b1, 1'b0});
            default: ;
         endcase
         step();
      end
      n_total++; if (px_q.size() !== 0) $display("FAIL pixel_leftover got=%0d exp=0", px_q.size()); else n_pass++;
      px_q.delete(); obs_q.delete();
   endtask

   task automatic test_overrun();
      int t0;
      do_reset();
      t0 = cyc;
      frame_tick = 1'b1;
      exp_q.push_back('{1, t0 + 1});
      exp_q.push_back('{2, t0 + 12});
      exp_q.push_back('{3, t0 + 23});
      exp_q.push_back('{1, t0 + 35});
      step();
      while (cyc < t0 + 36) begin
         frame_tick = (cyc == t0 + 3) || (cyc == t0 + 5) || (cyc == t0 + 7);
         if (cyc == t0 + 4) begin
            n_total++; if (overrun !== 8'd0) $display("FAIL overrun_first_busy_tick got=%0d exp=0", overrun); else n_pass++;
         end
         if (cyc == t0 + 6) begin
            n_total++; if (overrun !== 8'd1) $display("FAIL overrun_second_tick got=%0d exp=1", overrun); else n_pass++;
         end
         step();
      end
      frame_tick = 1'b0;
      n_total++; if (overrun !== 8'd2) $display("FAIL overrun_three_ticks got=%0d exp=2", overrun); else n_pass++;
      n_total++; if (obs_q.size() < 4) $display("FAIL overrun_event_count got=%0d exp=4", obs_q.size()); else n_pass++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         ev_t e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_total++;
         if (o.kind !== e.kind || o.cyc !== e.cyc)
            $display("FAIL overrun_event got=kind%0d@%0d exp=kind%0d@%0d", o.kind, o.cyc - t0, e.kind, e.cyc - t0);
         else n_pass++;
      end
      frame_tick = 1'b1;
      for (int i = 0; i < 300; i++) step();
      frame_tick = 1'b0;
      n_total++; if (overrun !== 8'd255) $display("FAIL overrun_saturate got=%0d exp=255", overrun); else n_pass++;
      step();
      n_total++; if (overrun !== 8'd255) $display("FAIL overrun_hold got=%0d exp=255", overrun); else n_pass++;
      do_reset();
      n_total++; if (overrun !== 8'd0) $display("FAIL overrun_reset got=%0d exp=0", overrun); else n_pass++;
   endtask

   task automatic test_watchdog();
      int t0, busy_n, guard;
      logic we_last;
      do_reset();
      clr_dly = 0;
      clear_x = 20; clear_y = 30;
      t0 = cyc;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      busy_n = 0; guard = 0; we_last = 1'b0;
      while (busy === 1'b1 && guard < 200) begin
         busy_n++;
         if (cyc == t0 + 64) we_last = pix_we;
         step();
         guard++;
      end
      n_total++; if (busy_n !== 64) $display("FAIL wdog_clear_cycles got=%0d exp=64", busy_n); else n_pass++;
      n_total++; if (wdog_err !== 1'b1) $display("FAIL wdog_err_set got=%b exp=1", wdog_err); else n_pass++;
      n_total++; if (we_last !== 1'b1) $display("FAIL wdog_we_before got=%b exp=1", we_last); else n_pass++;
      n_total++; if (pix_we !== 1'b0) $display("FAIL wdog_we_after got=%b exp=0", pix_we); else n_pass++;
      clr_dly = 10;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      busy_n = 0; guard = 0;
      while (busy === 1'b1 && guard < 200) begin
         busy_n++;
         step();
         guard++;
      end
      n_total++; if (busy_n !== 33) $display("FAIL wdog_normal_frame got=%0d exp=33", busy_n); else n_pass++;
      n_total++; if (wdog_err !== 1'b1) $display("FAIL wdog_err_sticky got=%b exp=1", wdog_err); else n_pass++;
      do_reset();
      n_total++; if (wdog_err !== 1'b0) $display("FAIL wdog_err_reset got=%b exp=0", wdog_err); else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      for (int i = 0; i < 15; i++) begin
         frame_tick = (i == 4);
         step();
      end
      frame_tick = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      obs_q.delete();
      n_total++; if (busy !== 1'b0) $display("FAIL midreset_busy got=%b exp=0", busy); else n_pass++;
      for (int i = 0; i < 40; i++) step();
      n_total++; if (obs_q.size() !== 0) $display("FAIL midreset_no_starts got=%0d exp=0", obs_q.size()); else n_pass++;
      obs_q.delete();
   endtask

   task automatic test_pause();
      int t0, guard;
      do_reset();
      pause = 1'b1;
      t0 = cyc;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
`ifdef PAUSE_EN
      for (int i = 0; i < 5; i++) step();
      n_total++; if (obs_q.size() !== 0) $display("FAIL pause_blocks got=%0d starts exp=0", obs_q.size()); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL pause_busy got=%b exp=0", busy); else n_pass++;
      t0 = cyc;
      pause = 1'b0;
      step();
      n_total++; if (clear_start !== 1'b1) $display("FAIL pause_release got=%b exp=1", clear_start); else n_pass++;
`else
      n_total++;
      if (obs_q.size() < 1 || obs_q[0].kind !== 1 || obs_q[0].cyc !== t0 + 1)
         $display("FAIL pause_ignored got=%0d starts exp=clear_start at cycle 1", obs_q.size());
      else n_pass++;
`endif
      pause = 1'b0;
      guard = 0;
      while (busy === 1'b1 && guard < 100) begin step(); guard++; end
      n_total++; if (busy !== 1'b0) $display("FAIL pause_frame_done got=%b exp=0", busy); else n_pass++;
      obs_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      cyc = 0; n_pass = 0; n_total = 0;
      clr_dly = 10; phy_dly = 10; drw_dly = 10;
      clr_tmr = 0; phy_tmr = 0; drw_tmr = 0;
      reset = 1'b1; frame_tick = 1'b0; pause = 1'b0;
      clear_done = 1'b0; physics_done = 1'b0; draw_done = 1'b0;
      clear_x = 0; clear_y = 0; draw_x = 0; draw_y = 0;
      test_reset();
      test_frame();
      test_pixels();
      test_overrun();
      test_watchdog();
      test_reset_mid();
      test_pause();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
